instr_fetch_port: RTL and testbench

INSTR_FETCH_PORT -- requirements
Module: instr_fetch_port

---
 rtl/instr_fetch_port_pkg.sv | 15 +
 rtl/instr_fetch_port.sv | 103 ++++++++++
 tb/tb_instr_fetch_port.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_port_pkg.sv
// Shared opcodes for the fetch path: the NOP word and the fetch-port FSM encoding.
`ifndef INSTR_NOP
`define INSTR_NOP 64'h0000_0000_0000_0013
`endif

package instr_fetch_port_pkg;

  localparam logic [63:0] INSTR_NOP = `INSTR_NOP;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/instr_fetch_port.sv
// Instruction fetch port: one-line buffer in front of a request/ack read bus.
// Hits return combinationally; a miss stalls at least 2 cycles until the fill lands.
module instr_fetch_port
  import instr_fetch_port_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_read_in,
  input  logic [63:0] fetch_addr_in,
  input  logic        invalidate_in,
  output logic [63:0] instr_value_out,
  output logic        fault_out,
  output logic        stall_out,
  output logic        bus_req_out,
  output logic [63:0] bus_addr_out,
  input  logic        bus_ack_in,
  input  logic [63:0] bus_rdata_in,
  input  logic        bus_err_in
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             buf_valid, buf_valid_nxt;
  logic [63:3]      buf_tag, buf_tag_nxt;
  logic [63:0]      buf_data, buf_data_nxt;
  logic             buf_err, buf_err_nxt;
  logic             req_nxt;
  logic [63:0]      addr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hit;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr_in[2:0];

  assign hit             = fetch_read_in & buf_valid & (buf_tag == fetch_addr_in[63:3]);
  assign instr_value_out = hit ? buf_data : INSTR_NOP;
  assign fault_out       = hit & buf_err;
  assign stall_out       = fetch_read_in & ~hit;

  always_comb begin
    state_nxt     = state;
    buf_valid_nxt = buf_valid;
    buf_tag_nxt   = buf_tag;
    buf_data_nxt  = buf_data;
    buf_err_nxt   = buf_err;
    req_nxt       = bus_req_out;
    addr_nxt      = bus_addr_out;
    cnt_nxt       = cnt;
    case (state)
      IDLE: begin
        if (fetch_read_in && !hit && !invalidate_in) begin
          state_nxt = BUSY;
          req_nxt   = 1'b1;
          addr_nxt  = {fetch_addr_in[63:3], 3'b000};
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        // A timeout fills the line exactly like an errored ack so the fetch stage sees a fault.
        if (bus_ack_in || (cnt == CNT_LAST)) begin
          buf_tag_nxt   = bus_addr_out[63:3];
          buf_data_nxt  = (bus_ack_in && !bus_err_in) ? bus_rdata_in : INSTR_NOP;
          buf_err_nxt   = bus_ack_in ? bus_err_in : 1'b1;
          buf_valid_nxt = 1'b1;
          req_nxt       = 1'b0;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Invalidate overrides a fill landing in the same cycle.
    if (invalidate_in) buf_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_data     <= INSTR_NOP;
      buf_err      <= 1'b0;
      bus_req_out  <= 1'b0;
      bus_addr_out <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      buf_valid    <= buf_valid_nxt;
      buf_tag      <= buf_tag_nxt;
      buf_data     <= buf_data_nxt;
      buf_err      <= buf_err_nxt;
      bus_req_out  <= req_nxt;
      bus_addr_out <= addr_nxt;
      cnt          <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_port.sv
// Bench for instr_fetch_port: directed scenarios then random traffic against a line/request model.
module tb_instr_fetch_port;

  localparam int          TO  = 4;
  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_read;
  logic [63:0] fetch_addr;
  logic        invalidate;
  logic [63:0] instr_value;
  logic        fault;
  logic        stall;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  // Reference: the cached line, plus the one outstanding bus read and how long it has waited.
  logic        m_valid;
  logic [60:0] m_tag;
  logic [63:0] m_data;
  logic        m_err;
  logic        m_pend;
  logic [63:0] m_baddr;
  int          m_age;

  logic [63:0] o_instr, o_addr;
  logic        o_stall, o_fault, o_req;

  always #5 clk = ~clk;

  instr_fetch_port #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_read_in  (fetch_read),
    .fetch_addr_in  (fetch_addr),
    .invalidate_in  (invalidate),
    .instr_value_out(instr_value),
    .fault_out      (fault),
    .stall_out      (stall),
    .bus_req_out    (bus_req),
    .bus_addr_out   (bus_addr),
    .bus_ack_in     (bus_ack),
    .bus_rdata_in   (bus_rdata),
    .bus_err_in     (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_tag = '0; m_data = NOP; m_err = 1'b0;
    m_pend = 1'b0; m_baddr = '0; m_age = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic rd, input logic [63:0] a, input logic inv,
                      input logic ack, input logic err, input logic [63:0] rdata);
    logic h;
    fetch_read = rd; fetch_addr = a; invalidate = inv;
    bus_ack = ack; bus_err = err; bus_rdata = rdata;
    #1;
    o_instr = instr_value; o_fault = fault; o_stall = stall; o_req = bus_req; o_addr = bus_addr;
    h = rd && m_valid && (m_tag == a[63:3]);
    check("stall", stall, {63'd0, rd && !h});
    check("instr", instr_value, h ? m_data : NOP);
    check("fault", fault, {63'd0, h && m_err});
    check("bus_req", bus_req, {63'd0, m_pend});
    check("bus_addr", bus_addr, m_baddr);
    if (m_pend) begin
      if (ack || (m_age + 1 == TO)) begin
        m_tag   = m_baddr[63:3];
        m_data  = (ack && !err) ? rdata : NOP;
        m_err   = ack ? err : 1'b1;
        m_valid = 1'b1;
        m_pend  = 1'b0;
      end else begin
        m_age++;
      end
    end else if (rd && !h && !inv) begin
      m_pend  = 1'b1;
      m_baddr = {a[63:3], 3'b000};
      m_age   = 0;
    end
    if (inv) m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    fetch_read = 1'b0; invalidate = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_bus_req", bus_req, 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          n;
    logic [63:0] base, a;
    logic        rd, inv, ack, err;
    fetch_addr = '0; bus_rdata = '0;
    do_reset();

    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("idle_no_stall", o_stall, 64'd0);

    // Cold miss on 0x1000 with a next-cycle ack.
    step(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("cold_stall0", o_stall, 64'd1);
    step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b0, 64'h13);
    check("cold_req", o_req, 64'd1);
    check("cold_addr", o_addr, 64'h1000);
    check("cold_stall1", o_stall, 64'd1);
    step(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("cold_hit_stall", o_stall, 64'd0);
    check("cold_hit_instr", o_instr, 64'h13);
    check("cold_hit_fault", o_fault, 64'd0);

    // Same line, different offset.
    step(1'b1, 64'h1004, 1'b0, 1'b0, 1'b0, 64'h0);
    check("hit_stall", o_stall, 64'd0);
    step(1'b1, 64'h1004, 1'b0, 1'b0, 1'b0, 64'h0);
    check("hit_no_req", o_req, 64'd0);

    // Redirect while busy: outstanding fill still lands under 0x1000.
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("redir_addr_hold", o_addr, 64'h1000);
    step(1'b1, 64'h2000, 1'b0, 1'b1, 1'b0, 64'hAAAA_0000_0000_AAAA);
    check("redir_addr_ack", o_addr, 64'h1000);
    step(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("redir_miss", o_stall, 64'd1);
    step(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("redir_new_addr", o_addr, 64'h2000);
    check("redir_new_req", o_req, 64'd1);
    step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b0, 64'hBBBB_0000_0000_BBBB);
    check("redir_old_tag", o_instr, 64'hAAAA_0000_0000_AAAA);
    step(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("redir_new_data", o_instr, 64'hBBBB_0000_0000_BBBB);

    // Bus error.
    step(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h3000, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    step(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("err_instr", o_instr, NOP);
    check("err_fault", o_fault, 64'd1);
    check("err_stall", o_stall, 64'd0);

    // Timeout with TIMEOUT=4.
    step(1'b1, 64'h4000, 1'b0, 1'b0, 1'b0, 64'h0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'h4000, 1'b0, 1'b0, 1'b0, 64'h0);
      n += int'(o_req);
    end
    check("to_req_cycles", 64'(n), 64'd4);
    check("to_fault", o_fault, 64'd1);
    check("to_instr", o_instr, NOP);
    check("to_stall", o_stall, 64'd0);

    // Invalidate coincident with ack, then reset mid-request and a stray ack.
    step(1'b1, 64'h5000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h5000, 1'b1, 1'b1, 1'b0, 64'h55);
    step(1'b1, 64'h5000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("inv_ack_miss", o_stall, 64'd1);
    step(1'b1, 64'h5000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("pre_rst_req", o_req, 64'd1);
    do_reset();
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h77);
    step(1'b1, 64'h5000, 1'b0, 1'b0, 1'b0, 64'h0);
    check("post_rst_miss", o_stall, 64'd1);
    check("stray_ack_req", o_req, 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0: base = 64'h1000;
          1: base = 64'h1008;
          2: base = 64'h2000;
          default: base = 64'hFFFF_FFFF_FFFF_FFF8;
        endcase
        a   = base | 64'($urandom_range(0, 7));
        rd  = ($urandom_range(0, 9) < 8);
        inv = ($urandom_range(0, 19) == 0);
        ack = m_pend ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
        err = ($urandom_range(0, 4) == 0);
        step(rd, a, inv, ack, err, {$urandom, $urandom});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
